// File: rtl/bf_iteration_sequencer.sv
// bf_iteration_sequencer: control FSM for Bellman-Ford relaxation sweeps.
// Runs READ -> DRAIN -> WRITE -> CHECK iterations until a sweep makes no
// distance update or NODES-1 iterations have completed, then pulses finish.
// Optional feature macro: NEG_CYCLE_CHECK_EN adds one verification sweep
// (writes suppressed) after the last iteration to flag a negative cycle.
// Handshake: start is a level sampled only in IDLE; iteration_done is a
// one-cycle AGU pulse honoured only in READ/WRITE; abort wins in any state.
module bf_iteration_sequencer #(
  parameter int NODES    = 8,
  parameter int ITER_W   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_global,
  input  logic              start,
  input  logic              abort,
  input  logic              iteration_done,
  input  logic              changed,
  output logic              read_enable,
  output logic              write_enable,
  output logic              busy,
  output logic              finish,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              neg_cycle
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = (PIPE_LAT > 0) ? DW'(PIPE_LAT - 1) : '0;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NODES - 1);
`ifdef NEG_CYCLE_CHECK_EN
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NODES);
`else
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NODES - 1);
`endif

  state_t            state;
  state_t            state_next;
  logic              change_flag;
  logic [DW-1:0]     drain_cnt;
  logic              extra_sweep;
  logic              extra_start;
  logic [ITER_W-1:0] iter_inc;

  // Saturating increment: the counter never wraps past its ceiling.
  assign iter_inc = (iter_count == ITER_MAX) ? iter_count : iter_count + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_global) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_next  = state;
    extra_start = 1'b0;
    case (state)
      IDLE:  if (start && !abort) state_next = READ;
      READ:  if (iteration_done) state_next = (PIPE_LAT == 0) ? WRITE : DRAIN;
      DRAIN: if (drain_cnt == '0) state_next = WRITE;
      WRITE: if (iteration_done) state_next = CHECK;
      CHECK: begin
        if (extra_sweep) begin
          state_next = DONE;
        end else if (!change_flag) begin
          state_next = DONE;
        end else if (iter_inc == LAST_ITER) begin
`ifdef NEG_CYCLE_CHECK_EN
          state_next  = READ;
          extra_start = 1'b1;
`else
          state_next  = DONE;
`endif
        end else begin
          state_next = READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end

  // Registered outputs, iteration bookkeeping, change flag and drain timer.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      converged    <= 1'b0;
      iter_count   <= '0;
      change_flag  <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      read_enable  <= (state_next == READ);
      write_enable <= (state_next == WRITE) && !extra_sweep;
      busy         <= (state_next != IDLE);
      finish       <= (state_next == DONE);
      if (state == IDLE && state_next == READ) begin
        iter_count <= '0;
        converged  <= 1'b0;
      end
      if (state_next == READ && state != READ)
        change_flag <= 1'b0;
      else if (state == WRITE)
        change_flag <= change_flag | changed;
      if (state != DRAIN && state_next == DRAIN)
        drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      if (state == CHECK && state_next != IDLE)
        iter_count <= iter_inc;
      if (state == CHECK && state_next == DONE && !change_flag && !extra_sweep)
        converged <= 1'b1;
    end
  end

`ifdef NEG_CYCLE_CHECK_EN
  // Verification sweep control and negative-cycle verdict.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      extra_sweep <= 1'b0;
      neg_cycle   <= 1'b0;
    end else begin
      if (state == IDLE && state_next == READ) begin
        extra_sweep <= 1'b0;
        neg_cycle   <= 1'b0;
      end else if (extra_start) begin
        extra_sweep <= 1'b1;
      end else if (state == CHECK && state_next == DONE && extra_sweep) begin
        neg_cycle <= change_flag;
      end
    end
  end
`else
  assign extra_sweep = 1'b0;
  assign neg_cycle   = 1'b0;
`endif

endmodule

// File: tb/tb_bf_iteration_sequencer.sv
// Directed bench for bf_iteration_sequencer: an AGU/datapath driver walks
// each sweep cycle by cycle and checks enables, timing and run results.
module tb_bf_iteration_sequencer;

  logic       clk = 1'b0;
  logic       rst_global = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       iteration_done = 1'b0;
  logic       changed = 1'b0;
  logic       read_enable;
  logic       write_enable;
  logic       busy;
  logic       finish;
  logic       converged;
  logic [3:0] iter_count;
  logic       neg_cycle;

  int total = 0;
  int bad   = 0;

  bf_iteration_sequencer #(.NODES(8), .ITER_W(4), .PIPE_LAT(3)) dut (
    .clk            (clk),
    .rst_global     (rst_global),
    .start          (start),
    .abort          (abort),
    .iteration_done (iteration_done),
    .changed        (changed),
    .read_enable    (read_enable),
    .write_enable   (write_enable),
    .busy           (busy),
    .finish         (finish),
    .converged      (converged),
    .iter_count     (iter_count),
    .neg_cycle      (neg_cycle)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance one cycle; all driving and sampling happens 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One AGU sweep: 8 read cycles, 3 drain cycles, 8 write cycles, 1 check.
  // mask bit w drives changed on write cycle w; abort_at aborts on that
  // write cycle; start_at pulses start on that read cycle.
  task automatic do_sweep(input logic [7:0] mask, input logic exp_we,
                          input int abort_at, input int start_at);
    int waited = 0;
    while (read_enable !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (read_enable !== 1'b1 || write_enable !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL read_phase[%0d]: re=%b we=%b busy=%b want 1 0 1", i, read_enable, write_enable, busy);
        bad++;
      end
      iteration_done = (i == 7);
      start = (i == start_at);
      step();
      iteration_done = 1'b0;
      start = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (read_enable !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL drain[%0d]: re=%b we=%b busy=%b want 0 0 1", d, read_enable, write_enable, busy);
        bad++;
      end
      step();
    end
    for (int w = 0; w < 8; w++) begin
      total++;
      if (write_enable !== exp_we || read_enable !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL write_phase[%0d]: we=%b re=%b busy=%b want %b 0 1", w, write_enable, read_enable, busy, exp_we);
        bad++;
      end
      changed = mask[w];
      iteration_done = (w == 7);
      abort = (w == abort_at);
      step();
      changed = 1'b0;
      iteration_done = 1'b0;
      abort = 1'b0;
      if (w == abort_at) return;
    end
    total++;
    if (read_enable !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1 || finish !== 1'b0) begin
      $display("FAIL check_cycle: re=%b we=%b busy=%b fin=%b want 0 0 1 0", read_enable, write_enable, busy, finish);
      bad++;
    end
    step();
  endtask

  task automatic test_reset();
    rst_global = 1'b1;
    step();
    step();
    rst_global = 1'b0;
    total++;
    if ({read_enable, write_enable, busy, finish, converged, neg_cycle} !== 6'b0 || iter_count !== 4'd0) begin
      $display("FAIL reset: outs=%b iter=%0d want 000000 0",
               {read_enable, write_enable, busy, finish, converged, neg_cycle}, iter_count);
      bad++;
    end
    iteration_done = 1'b1;
    step();
    iteration_done = 1'b0;
    total++;
    if (busy !== 1'b0 || read_enable !== 1'b0) begin
      $display("FAIL idle_iter_done: busy=%b re=%b want 0 0", busy, read_enable);
      bad++;
    end
  endtask

  task automatic test_full_run();
    pulse_start();
    total++;
    if (busy !== 1'b1 || read_enable !== 1'b1) begin
      $display("FAIL start_busy: busy=%b re=%b want 1 1", busy, read_enable);
      bad++;
    end
    for (int s = 1; s <= 7; s++) begin
      do_sweep(8'hFF, 1'b1, -1, -1);
      total++;
      if (iter_count !== 4'(s)) begin
        $display("FAIL full_iter[%0d]: iter=%0d want %0d", s, iter_count, s);
        bad++;
      end
    end
`ifdef NEG_CYCLE_CHECK_EN
    do_sweep(8'hFF, 1'b0, -1, -1);
    total++;
    if (iter_count !== 4'd8 || neg_cycle !== 1'b1) begin
      $display("FAIL neg_sweep: iter=%0d neg=%b want 8 1", iter_count, neg_cycle);
      bad++;
    end
`endif
    total++;
    if (finish !== 1'b1 || converged !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL full_done: fin=%b conv=%b busy=%b want 1 0 1", finish, converged, busy);
      bad++;
    end
`ifndef NEG_CYCLE_CHECK_EN
    total++;
    if (neg_cycle !== 1'b0) begin
      $display("FAIL full_neg: neg=%b want 0", neg_cycle);
      bad++;
    end
`endif
    step();
    total++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL full_after: fin=%b busy=%b want 0 0", finish, busy);
      bad++;
    end
  endtask

  task automatic test_early_converge();
    pulse_start();
    do_sweep(8'hFF, 1'b1, -1, -1);
    do_sweep(8'h3C, 1'b1, -1, -1);
    do_sweep(8'h00, 1'b1, -1, -1);
    total++;
    if (finish !== 1'b1 || converged !== 1'b1 || iter_count !== 4'd3) begin
      $display("FAIL conv_done: fin=%b conv=%b iter=%0d want 1 1 3", finish, converged, iter_count);
      bad++;
    end
    step();
    step();
    total++;
    if (finish !== 1'b0 || converged !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL conv_hold: fin=%b conv=%b busy=%b want 0 1 0", finish, converged, busy);
      bad++;
    end
    pulse_start();
    total++;
    if (converged !== 1'b0 || iter_count !== 4'd0 || read_enable !== 1'b1) begin
      $display("FAIL conv_restart: conv=%b iter=%0d re=%b want 0 0 1", converged, iter_count, read_enable);
      bad++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || read_enable !== 1'b0 || finish !== 1'b0) begin
      $display("FAIL abort_read: busy=%b re=%b fin=%b want 0 0 0", busy, read_enable, finish);
      bad++;
    end
  endtask

  task automatic test_abort();
    pulse_start();
    do_sweep(8'hFF, 1'b1, -1, -1);
    total++;
    if (iter_count !== 4'd1) begin
      $display("FAIL abort_pre_iter: iter=%0d want 1", iter_count);
      bad++;
    end
    do_sweep(8'hFF, 1'b1, 7, -1);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (read_enable !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0 ||
          finish !== 1'b0 || iter_count !== 4'd1) begin
        $display("FAIL abort_idle[%0d]: re=%b we=%b busy=%b fin=%b iter=%0d want 0 0 0 0 1",
                 c, read_enable, write_enable, busy, finish, iter_count);
        bad++;
      end
      step();
    end
    pulse_start();
    total++;
    if (iter_count !== 4'd0 || busy !== 1'b1) begin
      $display("FAIL abort_restart: iter=%0d busy=%b want 0 1", iter_count, busy);
      bad++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_last_cycle_change();
    pulse_start();
    do_sweep(8'h80, 1'b1, -1, 2);
    total++;
    if (iter_count !== 4'd1 || busy !== 1'b1 || read_enable !== 1'b1) begin
      $display("FAIL last_change: iter=%0d busy=%b re=%b want 1 1 1", iter_count, busy, read_enable);
      bad++;
    end
    do_sweep(8'h00, 1'b1, -1, -1);
    total++;
    if (finish !== 1'b1 || converged !== 1'b1 || iter_count !== 4'd2) begin
      $display("FAIL last_done: fin=%b conv=%b iter=%0d want 1 1 2", finish, converged, iter_count);
      bad++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || read_enable !== 1'b0 || finish !== 1'b0) begin
      $display("FAIL start_in_done: busy=%b re=%b fin=%b want 0 0 0", busy, read_enable, finish);
      bad++;
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    step();
    step();
    rst_global = 1'b1;
    step();
    rst_global = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (busy !== 1'b0 || finish !== 1'b0 || read_enable !== 1'b0 || iter_count !== 4'd0) begin
        $display("FAIL reset_mid[%0d]: busy=%b fin=%b re=%b iter=%0d want 0 0 0 0",
                 c, busy, finish, read_enable, iter_count);
        bad++;
      end
      step();
    end
  endtask

  // Test sequence and summary.
  initial begin
    step();
    test_reset();
    test_full_run();
    test_early_converge();
    test_abort();
    test_last_cycle_change();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
